// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed transmit path.
//   - tx_code_e : request codes presented on tx_packet
//   - PID_*     : 4-bit packet identifiers
//   - SYNC_BYTE : SYNC pattern, sent LSB-first
//   - CRC16_*   : data CRC polynomial and seed
//   - LINE_*    : {dp, dm} line states
//   - crc16_step: one-bit CRC16 update, LSB-first data order
package usb_pkg;

  typedef enum logic [2:0] {
    TX_NONE  = 3'd0,
    TX_DATA0 = 3'd1,
    TX_DATA1 = 3'd2,
    TX_ACK   = 3'd3,
    TX_NAK   = 3'd4,
    TX_STALL = 3'd5
  } tx_code_e;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

  function automatic logic [3:0] pid_of(input tx_code_e code);
    logic [3:0] pid;
    case (code)
      TX_DATA0: pid = PID_DATA0;
      TX_DATA1: pid = PID_DATA1;
      TX_ACK:   pid = PID_ACK;
      TX_NAK:   pid = PID_NAK;
      TX_STALL: pid = PID_STALL;
      default:  pid = 4'h0;
    endcase
    return pid;
  endfunction

endpackage

// File: rtl/usb_tx_bitproc.sv
// Line-side bit processor: bit stuffing plus NRZI encoding.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   bit_stb    : a new bit time starts at this edge
//   raw_bit    : unencoded bit for the new bit time
//   stuff_en   : raw_bit belongs to the stuffed region (PID..CRC)
//   line_se0   : drive SE0 for the new bit time
//   line_j     : drive J for the new bit time and return NRZI level to J
//   dp_out     : D+ line
//   dm_out     : D- line
//   stall      : the coming bit time carries a stuffed 0; caller must hold
module usb_tx_bitproc
  import usb_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic bit_stb,
  input  logic raw_bit,
  input  logic stuff_en,
  input  logic line_se0,
  input  logic line_j,
  output logic dp_out,
  output logic dm_out,
  output logic stall
);

  logic       level;     // 1 = J, 0 = K
  logic       se0;
  logic [2:0] ones_cnt;

  // Six 1s already on the line: the next bit time must be a stuffed 0.
  assign stall = (ones_cnt == 3'd6);

  assign {dp_out, dm_out} = se0 ? LINE_SE0 : (level ? LINE_J : LINE_K);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      level    <= 1'b1;
      se0      <= 1'b0;
      ones_cnt <= 3'd0;
    end else if (bit_stb) begin
      if (line_se0) begin
        se0      <= 1'b1;
        ones_cnt <= 3'd0;
      end else if (line_j) begin
        se0      <= 1'b0;
        level    <= 1'b1;
        ones_cnt <= 3'd0;
      end else if (stall) begin
        // stuffed 0: toggles the line like any other 0 and clears the run
        level    <= ~level;
        ones_cnt <= 3'd0;
      end else begin
        se0 <= 1'b0;
        if (!raw_bit) level <= ~level;
        ones_cnt <= (stuff_en && raw_bit) ? ones_cnt + 3'd1 : 3'd0;
      end
    end
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed packet transmitter (consumer end of the endpoint TX buffer).
// Sends SYNC, PID, optional payload + CRC16, then EOP.
// Ports:
//   clk, n_rst         : clock, asynchronous active-low reset
//   tx_packet          : request code (1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL)
//   buff_occ           : bytes held in the buffer, latched as payload length
//   TX_packet_data     : byte at the buffer read pointer
//   get_tx_data        : one-cycle strobe, advances the buffer read pointer
//   dp_out, dm_out     : USB lines
//   tx_transfer_active : high from request accept until idle restored
//   tx_error           : one-cycle pulse on an invalid request code
module usb_tx_encoder
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [2:0]                     tx_packet,
  input  logic [$clog2(MAX_BYTES+1)-1:0] buff_occ,
  input  logic [7:0]                     TX_packet_data,
  output logic                           get_tx_data,
  output logic                           dp_out,
  output logic                           dm_out,
  output logic                           tx_transfer_active,
  output logic                           tx_error
);

  localparam int CNT_W = $clog2(MAX_BYTES+1);
  localparam int BC_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(CLKS_PER_BIT - 1);
  localparam logic [BC_W-1:0] BIT_PRE  = BC_W'(CLKS_PER_BIT - 2);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_SYNC    = 4'd1;
  localparam logic [3:0] ST_PID     = 4'd2;
  localparam logic [3:0] ST_LOAD    = 4'd3;
  localparam logic [3:0] ST_DATA    = 4'd4;
  localparam logic [3:0] ST_CRC_HI  = 4'd5;
  localparam logic [3:0] ST_CRC_LO  = 4'd6;
  localparam logic [3:0] ST_EOP_SE0 = 4'd7;
  localparam logic [3:0] ST_EOP_J   = 4'd8;

  tx_code_e          code;
  logic [3:0]        state, state_n;
  logic [2:0]        bit_idx, idx_n;
  logic [BC_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]  byte_cnt, cnt_n;
  logic [3:0]        pid;
  logic              is_data;
  logic [7:0]        shift, shift_n;
  logic [15:0]       crc, crc_n;

  logic active, accept, bit_end, advance, load_due, byte_last, stall;
  logic slot_raw, slot_stuff, slot_se0, slot_j;

  assign code      = tx_code_e'(tx_packet);
  assign active    = (state != ST_IDLE);
  assign accept    = (state == ST_IDLE) && (tx_packet != 3'd0) && (tx_packet <= 3'd5);
  assign bit_end   = active && (bit_cnt == BIT_LAST);
  assign advance   = bit_end && !stall;
  assign byte_last = (bit_idx == 3'd7);

  // The buffer read happens in the last cycle of the bit preceding a byte, so
  // LOAD is entered one cycle early. A pending stuffed bit defers it by one bit.
  assign load_due = active && (bit_cnt == BIT_PRE) && !stall && byte_last &&
                    (byte_cnt != '0) &&
                    (((state == ST_PID) && is_data) || (state == ST_DATA));

  assign get_tx_data        = (state == ST_LOAD);
  assign tx_transfer_active = active;

  // Next-slot decode: at the end of each bit the FSM chooses the next bit time
  // and presents its raw value to the bit processor in the same cycle.
  always_comb begin
    state_n    = state;
    idx_n      = bit_idx;
    shift_n    = shift;
    crc_n      = crc;
    cnt_n      = byte_cnt;
    slot_raw   = 1'b1;
    slot_stuff = 1'b0;
    slot_se0   = 1'b0;
    slot_j     = 1'b0;

    if (accept) begin
      state_n  = ST_SYNC;
      idx_n    = 3'd0;
      shift_n  = SYNC_BYTE;
      crc_n    = CRC16_INIT;
      cnt_n    = ((code == TX_DATA0) || (code == TX_DATA1)) ? buff_occ : '0;
      slot_raw = SYNC_BYTE[0];
    end else if (load_due) begin
      state_n = ST_LOAD;
    end else if (advance) begin
      case (state)
        ST_SYNC: begin
          if (!byte_last) begin
            idx_n    = bit_idx + 3'd1;
            shift_n  = shift >> 1;
            slot_raw = shift[1];
          end else begin
            state_n    = ST_PID;
            idx_n      = 3'd0;
            shift_n    = {~pid, pid};
            slot_raw   = pid[0];
            slot_stuff = 1'b1;
          end
        end
        ST_PID: begin
          if (!byte_last) begin
            idx_n      = bit_idx + 3'd1;
            shift_n    = shift >> 1;
            slot_raw   = shift[1];
            slot_stuff = 1'b1;
          end else if (!is_data) begin
            state_n  = ST_EOP_SE0;
            idx_n    = 3'd0;
            slot_se0 = 1'b1;
          end else begin
            // zero-length data packet: straight to CRC
            state_n    = ST_CRC_HI;
            idx_n      = 3'd0;
            slot_raw   = ~crc[15];
            slot_stuff = 1'b1;
          end
        end
        ST_LOAD: begin
          state_n    = ST_DATA;
          idx_n      = 3'd0;
          shift_n    = TX_packet_data;
          slot_raw   = TX_packet_data[0];
          slot_stuff = 1'b1;
          crc_n      = crc16_step(crc, TX_packet_data[0]);
          cnt_n      = byte_cnt - CNT_W'(1);
        end
        ST_DATA: begin
          if (!byte_last) begin
            idx_n      = bit_idx + 3'd1;
            shift_n    = shift >> 1;
            slot_raw   = shift[1];
            slot_stuff = 1'b1;
            crc_n      = crc16_step(crc, shift[1]);
          end else begin
            state_n    = ST_CRC_HI;
            idx_n      = 3'd0;
            slot_raw   = ~crc[15];
            slot_stuff = 1'b1;
          end
        end
        ST_CRC_HI, ST_CRC_LO: begin
          // the CRC register itself is the shifter; bit 15 is always on the line
          crc_n      = {crc[14:0], 1'b0};
          slot_raw   = ~crc[14];
          slot_stuff = 1'b1;
          idx_n      = bit_idx + 3'd1;
          if (byte_last) begin
            idx_n = 3'd0;
            if (state == ST_CRC_HI) begin
              state_n = ST_CRC_LO;
            end else begin
              state_n    = ST_EOP_SE0;
              slot_se0   = 1'b1;
              slot_stuff = 1'b0;
            end
          end
        end
        ST_EOP_SE0: begin
          if (bit_idx == 3'd0) begin
            idx_n    = 3'd1;
            slot_se0 = 1'b1;
          end else begin
            state_n = ST_EOP_J;
            idx_n   = 3'd0;
            slot_j  = 1'b1;
          end
        end
        ST_EOP_J: begin
          state_n = ST_IDLE;
          slot_j  = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Control state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      bit_idx  <= 3'd0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      pid      <= 4'h0;
      is_data  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state    <= state_n;
      bit_idx  <= idx_n;
      byte_cnt <= cnt_n;
      tx_error <= (state == ST_IDLE) && (tx_packet >= 3'd6);
      if (accept) begin
        pid     <= pid_of(code);
        is_data <= (code == TX_DATA0) || (code == TX_DATA1);
        bit_cnt <= '0;
      end else if (active) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BC_W'(1);
      end
    end
  end

  // Datapath: reseeded on every accept, so no reset needed
  always_ff @(posedge clk) begin
    shift <= shift_n;
    crc   <= crc_n;
  end

  usb_tx_bitproc u_bitproc (
    .clk      (clk),
    .n_rst    (n_rst),
    .bit_stb  (accept || bit_end),
    .raw_bit  (slot_raw),
    .stuff_en (slot_stuff),
    .line_se0 (slot_se0),
    .line_j   (slot_j),
    .dp_out   (dp_out),
    .dm_out   (dm_out),
    .stall    (stall)
  );

endmodule

// File: tb/tb_usb_tx_encoder.sv
module tb_usb_tx_encoder;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] buff_occ = 7'd0;
  logic [7:0] TX_packet_data;
  logic       get_tx_data, dp_out, dm_out, tx_transfer_active, tx_error;

  logic [7:0] pay [0:63];
  logic [6:0] rd_ptr;

  int checks = 0;
  int errors = 0;

  logic [1:0] line_q [$];
  int         pulse_q [$];

  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .MAX_BYTES(64)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .buff_occ           (buff_occ),
    .TX_packet_data     (TX_packet_data),
    .get_tx_data        (get_tx_data),
    .dp_out             (dp_out),
    .dm_out             (dm_out),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error)
  );

  always #5 clk = ~clk;

  // Buffer emulation: combinational read at the pointer, pointer advances on get_tx_data.
  assign TX_packet_data = pay[rd_ptr[5:0]];
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) rd_ptr <= 7'd0;
    else if (!tx_transfer_active && tx_packet != 3'd0) rd_ptr <= 7'd0;
    else if (get_tx_data) rd_ptr <= rd_ptr + 7'd1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic b);
    logic top;
    top = c[15];
    c = c << 1;
    if (top != b) c = c ^ 16'h8005;
    return c;
  endfunction

  // Expected line states per bit time and expected get_tx_data cycles.
  task automatic build_model(input logic [3:0] pid, input bit is_data, input int n,
                             output int total);
    bit          raw [$];
    bit          cnt [$];
    int          byte_at [$];
    logic [15:0] crc;
    logic [7:0]  sb, pb, db;
    bit          level;
    int          ones, slot, bi;
    sb = 8'h80;
    for (int i = 0; i < 8; i++) begin raw.push_back(sb[i]); cnt.push_back(1'b0); end
    pb = {~pid, pid};
    for (int i = 0; i < 8; i++) begin raw.push_back(pb[i]); cnt.push_back(1'b1); end
    if (is_data) begin
      crc = 16'hFFFF;
      for (int b = 0; b < n; b++) begin
        byte_at.push_back(raw.size());
        db = pay[b];
        for (int i = 0; i < 8; i++) begin
          raw.push_back(db[i]); cnt.push_back(1'b1);
          crc = ref_crc(crc, db[i]);
        end
      end
      for (int i = 15; i >= 0; i--) begin raw.push_back(~crc[i]); cnt.push_back(1'b1); end
    end
    level = 1'b1; ones = 0; slot = 0; bi = 0;
    for (int k = 0; k < raw.size(); k++) begin
      if (bi < byte_at.size() && byte_at[bi] == k) begin
        pulse_q.push_back(slot * CPB - 1);
        bi++;
      end
      if (!raw[k]) level = ~level;
      line_q.push_back(level ? 2'b10 : 2'b01);
      slot++;
      if (cnt[k] && raw[k]) begin
        ones++;
        if (ones == 6) begin
          level = ~level;
          line_q.push_back(level ? 2'b10 : 2'b01);
          slot++;
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
    line_q.push_back(2'b00);
    line_q.push_back(2'b00);
    line_q.push_back(2'b10);
    total = slot + 3;
  endtask

  // Call at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
  task automatic run_packet(input logic [2:0] code, input int n, input int inject_at,
                            input string name);
    logic [3:0] pid;
    bit         is_data, err_seen, act_drop;
    int         total, p;
    logic [1:0] ln, ex;
    case (code)
      3'd1: pid = 4'b0011;
      3'd2: pid = 4'b1011;
      3'd3: pid = 4'b0010;
      3'd4: pid = 4'b1010;
      default: pid = 4'b1110;
    endcase
    is_data = (code == 3'd1) || (code == 3'd2);
    line_q.delete();
    pulse_q.delete();
    build_model(pid, is_data, is_data ? n : 0, total);
    err_seen = 1'b0;
    act_drop = 1'b0;
    buff_occ  = 7'(n);
    tx_packet = code;
    @(posedge clk);
    #1;
    tx_packet = 3'd0;
    buff_occ  = 7'd50;
    for (int c = 0; c <= total * CPB; c++) begin
      @(negedge clk);
      if (c == inject_at) tx_packet = 3'd3;
      else if (c == inject_at + 1) tx_packet = 3'd0;
      ln = {dp_out, dm_out};
      if (tx_error) err_seen = 1'b1;
      if (c < total * CPB) begin
        if (!tx_transfer_active) act_drop = 1'b1;
        if (c % CPB == CPB / 2) begin
          checks++;
          ex = line_q.pop_front();
          if (ln !== ex) begin
            errors++;
            $display("FAIL %s line bit %0d got=%b exp=%b", name, c / CPB, ln, ex);
          end
        end
        if (get_tx_data !== 1'b0) begin
          checks++;
          if (pulse_q.size() == 0) begin
            errors++;
            $display("FAIL %s get_tx_data cycle %0d got=%b exp=0", name, c, get_tx_data);
          end else begin
            p = pulse_q.pop_front();
            if (p != c) begin
              errors++;
              $display("FAIL %s get_tx_data cycle got=%0d exp=%0d", name, c, p);
            end
          end
        end
      end else begin
        checks++;
        if (tx_transfer_active !== 1'b0 || ln !== 2'b10) begin
          errors++;
          $display("FAIL %s idle after EOP got active=%b line=%b exp active=0 line=10",
                   name, tx_transfer_active, ln);
        end
      end
    end
    checks++;
    if (err_seen) begin
      errors++;
      $display("FAIL %s tx_error got=1 exp=0", name);
    end
    checks++;
    if (act_drop) begin
      errors++;
      $display("FAIL %s tx_transfer_active got=0 exp=1 during packet", name);
    end
    checks++;
    if (pulse_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing get_tx_data got=%0d pending exp=0", name, pulse_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({dp_out, dm_out, get_tx_data, tx_transfer_active, tx_error} !== 5'b10000) begin
      errors++;
      $display("FAIL %s got dp=%b dm=%b get=%b act=%b err=%b exp 1 0 0 0 0", name,
               dp_out, dm_out, get_tx_data, tx_transfer_active, tx_error);
    end
  endtask

  task automatic test_reset();
    #2 n_rst = 1'b0;
    #1;
    check_idle_outputs("reset_async");
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_ack();
    run_packet(3'd3, 0, -1, "ack");
  endtask

  task automatic test_back_to_back();
    run_packet(3'd4, 0, -1, "nak_b2b");
    run_packet(3'd5, 0, -1, "stall_b2b");
  endtask

  task automatic test_zlp();
    run_packet(3'd1, 0, -1, "data0_zlp");
  endtask

  task automatic test_data4();
    for (int i = 0; i < 4; i++) pay[i] = 8'(i);
    run_packet(3'd2, 4, -1, "data1_4");
  endtask

  task automatic test_stuff();
    pay[0] = 8'hFF;
    run_packet(3'd1, 1, -1, "data0_ff");
    pay[0] = 8'h7E; pay[1] = 8'hFF; pay[2] = 8'hFF;
    run_packet(3'd2, 3, -1, "data1_ones");
  endtask

  task automatic test_error();
    tx_packet = 3'd7;
    @(posedge clk);
    #1;
    tx_packet = 3'd0;
    checks++;
    if (tx_error !== 1'b1 || {dp_out, dm_out} !== 2'b10 || tx_transfer_active !== 1'b0) begin
      errors++;
      $display("FAIL invalid_code got err=%b line=%b act=%b exp err=1 line=10 act=0",
               tx_error, {dp_out, dm_out}, tx_transfer_active);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_error !== 1'b0) begin
      errors++;
      $display("FAIL invalid_code_pulse got=%b exp=0", tx_error);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore();
    for (int i = 0; i < 4; i++) pay[i] = 8'(8'hA5 + i * 17);
    run_packet(3'd2, 4, 200, "data1_ignore_req");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) pay[i] = 8'(i);
    buff_occ  = 7'd4;
    tx_packet = 3'd2;
    @(posedge clk);
    #1;
    tx_packet = 3'd0;
    repeat (160) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_idle_outputs("reset_mid_data");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    run_packet(3'd3, 0, -1, "ack_after_reset");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) pay[i] = 8'h00;
    test_reset();
    test_ack();
    test_back_to_back();
    test_zlp();
    test_data4();
    test_stuff();
    test_error();
    test_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
- USB full-speed packet transmitter; the consumer end of the endpoint data buffer's TX path.
- On a transmit request it serialises SYNC, PID, optional data payload and CRC16 onto the D+/D- lines, then ends the packet with EOP.
- Each payload byte is pulled from the buffer with a one-cycle get_tx_data strobe.
- Bits are NRZI-encoded and bit-stuffed at CLKS_PER_BIT clocks per bit.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit time.
- MAX_BYTES, 64, largest payload; buffer occupancy never exceeds this.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- tx_packet  in  3  request code: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 invalid
- buff_occ  in  7  bytes currently held in the data buffer
- TX_packet_data  in  8  byte at the buffer read pointer (combinational from buffer)
- get_tx_data  out  1  one-cycle strobe; advances buffer read pointer
- dp_out  out  1  D+ line
- dm_out  out  1  D- line
- tx_transfer_active  out  1  high from request accept until idle restored
- tx_error  out  1  one-cycle pulse on invalid request code

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (n_rst).
- Reset values: dp_out=1, dm_out=0 (J/idle), get_tx_data=0, tx_transfer_active=0, tx_error=0, all counters 0, FSM IDLE, NRZI level J.
- FSM states: IDLE, SYNC, PID, LOAD, DATA, CRC_HI, CRC_LO, EOP_SE0, EOP_J.
- IDLE:
  - tx_packet sampled every cycle.
  - Codes 1-5: latch PID and byte count (buff_occ for DATA0/1, 0 for handshakes); go to SYNC; tx_transfer_active=1.
  - Codes 6/7: tx_error pulses 1 cycle; stay IDLE.
- tx_packet is ignored outside IDLE; no error is raised.
- Latency: the first SYNC bit appears on dp/dm in the cycle after the accepting edge.
- Each bit is held exactly CLKS_PER_BIT cycles, timed by a bit counter that runs continuously while active.
- SYNC: 8'h80 sent LSB-first (0000_0001), i.e. KJKJKJKK.
- PID: byte {~pid[3:0], pid[3:0]} sent LSB-first.
  - PID codes: DATA0 4'b0011, DATA1 4'b1011, ACK 4'b0010, NAK 4'b1010, STALL 4'b1110.
  - Handshake packets go PID -> EOP_SE0.
- Data packet, count>0:
  - LOAD captures TX_packet_data into the shift register and asserts get_tx_data for that single cycle.
  - LOAD costs no bit time; it is absorbed into the final cycle of the previous bit.
  - DATA shifts 8 bits LSB-first, decrements the count, then returns to LOAD or goes to CRC_HI when count hits 0.
- Zero-length data packet goes PID -> CRC_HI with no get_tx_data.
- CRC16:
  - Polynomial 0x8005, init 16'hFFFF, updated per payload bit before stuffing.
  - Transmitted as complemented remainder, crc[15] first, 16 bits across CRC_HI/CRC_LO.
- Bit stuffing:
  - Counts consecutive 1s in the raw stream from PID through CRC.
  - After the sixth 1, one extra bit time carries a stuffed 0, during which the shift register, CRC and byte count hold.
  - Counter clears on any 0, including stuffed 0s.
  - A stuffed bit may follow the last CRC bit, before EOP.
- NRZI: raw 0 toggles the line (J<->K); raw 1 holds it. J = dp1/dm0, K = dp0/dm1.
- EOP: SE0 (dp0/dm0) for 2 bit times, then J for 1 bit time. Then IDLE, tx_transfer_active=0, NRZI level reset to J.
- Back-to-back requests: a request can be accepted in the first IDLE cycle after EOP_J ends.
- Asynchronous reset mid-packet returns every output to its reset value immediately; no EOP is emitted.
- buff_occ changes after accept do not affect the latched count.

Decomposition:
- Shared package usb_pkg:
  - tx_packet code enum.
  - PID constants.
  - SYNC byte.
  - CRC16 polynomial/init.
  - J/K/SE0 line-state encoding.
- Sub-module usb_tx_bitproc, one instance:
  - Inputs: raw bit plus bit-strobe.
  - Performs bit stuffing and NRZI.
  - Outputs: dp/dm plus a stall flag that tells the FSM to hold.

Test Plan:
- ACK request (tx_packet=3): dp/dm carry KJKJKJKK, then raw PID 0xD2 LSB-first, then SE0,SE0,J; total 19 bit times = 152 cycles; get_tx_data never asserted.
- DATA0 with buff_occ=0: SYNC, PID 0xC3, CRC field all 16 raw bits 0 (16 line toggles), EOP; 35 bit times; no get_tx_data.
- DATA1 with buff_occ=4, bytes 00,01,02,03: exactly 4 get_tx_data pulses, one per byte, at byte boundaries; decoded payload and CRC match the bench CRC16 reference model.
- DATA0, buff_occ=1, byte 0xFF: stuffed 0 after the sixth 1, so the payload occupies 9 bit times; no stuffing before the 6th 1; CRC still matches the model.
- tx_packet=7 in IDLE -> tx_error high 1 cycle, lines stay J. tx_packet=3 during an active DATA packet -> ignored, no error.
- n_rst low in the middle of DATA -> within the same cycle dp=1, dm=0, tx_transfer_active=0; after release an ACK request transmits cleanly.
